reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Parametrised successor to the fixed 16x16 processor register file.
- Provides WIDTH-bit registers, DEPTH entries, two combinational read ports and one clocked write port.
- Adds a per-register busy scoreboard so the issue stage can detect RAW hazards against multi-cycle units.
- Sits between decode/issue (reads, reservations) and writeback (writes, busy release).

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 16, number of registers, 2..256, need not be a power of two.
- AW, 4, address width; must satisfy 2**AW >= DEPTH.
- ZERO_REG, 0, when 1 register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- Clear  in  1  synchronous active-low reset, sampled on rising clk.
- Aaddr  in  AW  read port A address.
- Baddr  in  AW  read port B address.
- A  out  WIDTH  read data for Aaddr.
- B  out  WIDTH  read data for Baddr.
- Caddr  in  AW  write address.
- C  in  WIDTH  write data.
- Load  in  1  write enable.
- Rsv  in  1  reserve request: mark Rsvaddr busy (producer issued).
- Rsvaddr  in  AW  register to reserve.
- Abusy  out  1  busy bit of Aaddr.
- Bbusy  out  1  busy bit of Baddr.
- Hazard  out  1  Abusy | Bbusy.
- Nbusy  out  AW+1  count of busy registers.

Behaviour:
- Reset: when Clear=0 at a clk edge, all registers become 0, all busy bits 0 and Nbusy 0. Reset overrides Load and Rsv in that cycle. After reset, A=B=0 and Abusy=Bbusy=Hazard=0.
- Reads:
  - A and B are combinational from current register state; no clock latency.
  - An address >= DEPTH reads 0 with busy 0.
  - With ZERO_REG=1, address 0 reads 0.
- Writes:
  - Load=1 with a valid Caddr writes C at the clk edge.
  - The new value is visible on A/B in the cycle after the edge (unless the optional bypass is enabled).
  - Writes to Caddr >= DEPTH are dropped.
  - Writes to register 0 are dropped when ZERO_REG=1.
- Scoreboard, per register, evaluated on each clk edge:
  - Rsv=1 on a valid Rsvaddr: busy[Rsvaddr] <- 1.
  - Load=1 on a valid Caddr: busy[Caddr] <- 0.
  - Rsv and Load on the same address in the same cycle: busy ends at 1 (the new producer wins); data is still written.
  - Rsv on an already-busy register: stays 1, no error.
  - Load on a non-busy register: allowed, busy stays 0.
  - Rsvaddr >= DEPTH, or address 0 with ZERO_REG=1: ignored.
- Nbusy:
  - Registered; always equals the population count of the busy bits after the edge.
  - Changes by -1, 0 or +1 per cycle.
  - Never exceeds DEPTH, never underflows.
- Hazard is purely combinational from the busy bits and Aaddr/Baddr. The block never stalls itself; issue logic owns stalling.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined:
  - If Load=1 and Caddr equals Aaddr (valid, and not a dropped zero-register write), A = C in the same cycle. The same rule applies to B.
  - Abusy/Bbusy for that address read 0 that cycle, unless Rsv targets the same address.
  - Gives write-first behaviour with 0-cycle writeback-to-read latency.
- Not defined:
  - A/B/Abusy/Bbusy reflect pre-edge state only.
  - A write is visible 1 cycle later.

Test Plan:
- Reset then read: Clear=0 for 2 cycles, then Clear=1 with Aaddr=4, Baddr=15 -> A=0, B=0, Hazard=0, Nbusy=0.
- Write/readback: Load=1, Caddr=4, C=16'h0003, one edge, then Load=0, Aaddr=4 -> A=16'h0003 from the next cycle. With BYPASS_EN, A=16'h0003 in the write cycle; without it, A=0 in the write cycle.
- Reserve/release: Rsv=1 at Rsvaddr=7, then Aaddr=7 -> Abusy=1, Hazard=1, Nbusy=1. Then Load=1, Caddr=7, C=16'hBEEF -> the next cycle shows Abusy=0, A=16'hBEEF, Nbusy=0.
- Simultaneous: register 3 busy, then Rsv=1 and Load=1 both to address 3 with C=16'h1234 -> register 3=16'h1234, busy[3]=1, Nbusy unchanged.
- ZERO_REG=1, DEPTH=12:
  - Load to address 0 with C=16'hFFFF -> A(0)=0.
  - Rsv to address 0 -> Abusy=0.
  - Load to address 13 -> no register changes; reading address 13 gives 0.
- Reset mid-operation: busy bits set on 5 registers (Nbusy=5), then Clear=0 together with Load=1 to address 2 -> all registers 0, Nbusy=0, and register 2 is not written.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two combinational read ports,
// one clocked write port and a per-register busy scoreboard for RAW hazard
// detection against multi-cycle producers.
//
// Optional build macro REG_FILE_SB_BYPASS_EN: when defined, a write in flight
// is forwarded to a matching read port in the same cycle (write-first), and
// the busy bit seen on that port reflects the release. When undefined, read
// ports show pre-edge state only and a write becomes visible one cycle later.
module reg_file_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             Clear,
    input  logic [AW-1:0]    Aaddr,
    input  logic [AW-1:0]    Baddr,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [AW-1:0]    Caddr,
    input  logic [WIDTH-1:0] C,
    input  logic             Load,
    input  logic             Rsv,
    input  logic [AW-1:0]    Rsvaddr,
    output logic             Abusy,
    output logic             Bbusy,
    output logic             Hazard,
    output logic [AW:0]      Nbusy
);

    // DEPTH fits in AW+1 bits because 2**AW >= DEPTH.
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;

    logic load_ok;
    logic rsv_ok;
    logic rsv_new;
    logic load_clr;

    // An address is usable when it is in range and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_L) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    assign load_ok = Load && addr_ok(Caddr);
    assign rsv_ok  = Rsv && addr_ok(Rsvaddr);

    // Population count moves by at most one per edge: one reservation can add a
    // busy bit and one writeback can remove one; a same-address pair cancels
    // the release because the new producer keeps the register busy.
    always_comb begin
        rsv_new  = 1'b0;
        load_clr = 1'b0;
        if (rsv_ok && !busy[Rsvaddr]) begin
            rsv_new = 1'b1;
        end
        if (load_ok && busy[Caddr] && !(rsv_ok && (Rsvaddr == Caddr))) begin
            load_clr = 1'b1;
        end
    end

    // Register storage: synchronous clear, otherwise write on Load.
    always_ff @(posedge clk) begin
        if (!Clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load_ok && (Caddr == AW'(i))) begin
                    regs[i] <= C;
                end
            end
        end
    end

    // Busy scoreboard: reservation sets, writeback clears, reservation wins on a tie.
    always_ff @(posedge clk) begin
        if (!Clear) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rsv_ok && (Rsvaddr == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (load_ok && (Caddr == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Busy count tracks the scoreboard incrementally.
    always_ff @(posedge clk) begin
        if (!Clear) begin
            Nbusy <= '0;
        end else begin
            case ({rsv_new, load_clr})
                2'b10:   Nbusy <= Nbusy + ONE_L;
                2'b01:   Nbusy <= Nbusy - ONE_L;
                default: Nbusy <= Nbusy;
            endcase
        end
    end

    // Read port A: stored state, optionally overridden by a same-cycle write.
    always_comb begin
        A     = '0;
        Abusy = 1'b0;
        if (addr_ok(Aaddr)) begin
            A     = regs[Aaddr];
            Abusy = busy[Aaddr];
        end
`ifdef REG_FILE_SB_BYPASS_EN
        if (load_ok && (Caddr == Aaddr)) begin
            A     = C;
            Abusy = rsv_ok && (Rsvaddr == Aaddr);
        end
`endif
    end

    // Read port B: same rules as port A.
    always_comb begin
        B     = '0;
        Bbusy = 1'b0;
        if (addr_ok(Baddr)) begin
            B     = regs[Baddr];
            Bbusy = busy[Baddr];
        end
`ifdef REG_FILE_SB_BYPASS_EN
        if (load_ok && (Caddr == Baddr)) begin
            B     = C;
            Bbusy = rsv_ok && (Rsvaddr == Baddr);
        end
`endif
    end

    assign Hazard = Abusy | Bbusy;

endmodule
